// File: rtl/sram_access_ctrl.sv
// sram_access_ctrl
//   Sequencer in front of a single-row SRAM column. Accepts read/write
//   requests (valid/ready), steps the array through precharge and wordline
//   phases, samples the complementary sense outputs and returns the sensed
//   value with an error flag over a valid/ready response channel.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid/ready   request handshake (ready only in IDLE)
//   req_write         1 = write, 0 = read
//   req_data          write data
//   rsp_valid/ready   response handshake
//   rsp_data          captured sense value
//   rsp_err           unresolved bitline pair, or write readback mismatch
//   precharge_b       active-low bitline precharge (array ph2)
//   wordline          row select (array ph1)
//   we                write-driver enable
//   din               write-driver data
//   sense, sense_b    complementary sense outputs from the array
module sram_access_ctrl #(
  parameter int WIDTH      = 1,
  parameter int PRE_CYCLES = 1,
  parameter int WL_CYCLES  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [WIDTH-1:0] req_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic             precharge_b,
  output logic             wordline,
  output logic             we,
  output logic [WIDTH-1:0] din,
  input  logic [WIDTH-1:0] sense,
  input  logic [WIDTH-1:0] sense_b
);

  localparam int MAXC = (PRE_CYCLES > WL_CYCLES) ? PRE_CYCLES : WL_CYCLES;
  localparam int CW   = $clog2(MAXC) + 1;

  typedef enum logic [1:0] {IDLE, PRECHARGE, ACCESS, RESP} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          op_wr;
  logic          accept;
  logic          access_done;
  logic          err_nx;

  assign req_ready   = (state == IDLE);
  assign accept      = req_valid && req_ready;
  assign access_done = (state == ACCESS) && (cnt == '0);

  // A pair reading the same level on both rails never resolved; a write
  // additionally has to read back what was driven.
  assign err_nx = (|(~(sense ^ sense_b))) || (op_wr && (|(sense ^ din)));

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          cnt_nx   = CW'(PRE_CYCLES - 1);
          state_nx = PRECHARGE;
        end
      end
      PRECHARGE: begin
        if (cnt == '0) begin
          cnt_nx   = CW'(WL_CYCLES - 1);
          state_nx = ACCESS;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      ACCESS: begin
        if (cnt == '0) state_nx = RESP;
        else           cnt_nx   = cnt - CW'(1);
      end
      RESP: begin
        if (rsp_valid && rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      op_wr <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) op_wr <= req_write;
    end
  end

  // Array controls are registered from the next state so they switch
  // cleanly on the clock edge. precharge_b and wordline share one decode,
  // so precharge can never be active while the wordline is up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      precharge_b <= 1'b0;
      wordline    <= 1'b0;
      we          <= 1'b0;
      din         <= '0;
    end else begin
      precharge_b <= (state_nx == ACCESS);
      wordline    <= (state_nx == ACCESS);
      we          <= (state_nx == ACCESS) && op_wr;
      if (accept && req_write) din <= req_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else if (access_done) begin
      rsp_valid <= 1'b1;
      rsp_data  <= sense;
      rsp_err   <= err_nx;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule
